uart_transmitter: RTL

- Serial UART transmitter for the SAP-2 `computer` top level. It is the transmit end of the link whose receive end samples `uart_rx`.
- It takes bytes from the CPU's I/O write path and drives the `uart_tx` line with 8N1 frames, LSB first.
- It double-buffers: one holding register plus one shift register, so the CPU can queue a byte while another is on the wire.

---
 rtl/uart_transmitter_if.sv | 23 ++
 rtl/uart_transmitter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter_if.sv
// Byte write port of the UART transmitter: CPU-side strobe/ready plus busy status.
interface uart_transmitter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_i;
    logic                  valid_i;
    logic                  ready_o;
    logic                  busy_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  busy_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output busy_o
    );
endinterface

// File: rtl/uart_transmitter.sv
// Double-buffered 8N1 UART transmitter (holding reg + shifter).
// Define UART_TX_PARITY_EN for 8E1 frames with an even-parity bit.
module uart_transmitter #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic               clk,
    input  logic               reset,
    uart_transmitter_if.slave  bus,
    output logic               uart_tx
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         idx, idx_n;
    logic [7:0]         shifter, shift_n;
    logic [7:0]         hold, hold_n;
    logic               full, full_n;
    logic               tx_n;
    logic               accept;
    logic               bit_end;
`ifdef UART_TX_PARITY_EN
    logic               par, par_n;
`endif

    assign accept      = bus.valid_i && !full;
    assign bit_end     = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign bus.ready_o = !full;
    assign bus.busy_o  = (state != IDLE) || full;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shifter;
        hold_n  = hold;
        full_n  = full;
        tx_n    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (accept) begin
                    shift_n = bus.data_i;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^bus.data_i;
`endif
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shift_n = shifter >> 1;
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    // Chain straight into the next start bit when a byte waits.
                    if (full) begin
                        shift_n = hold;
                        full_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_n   = ^hold;
`endif
                        state_n = START;
                    end else if (accept) begin
                        shift_n = bus.data_i;
`ifdef UART_TX_PARITY_EN
                        par_n   = ^bus.data_i;
`endif
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (accept && state != IDLE && !(state == STOP && bit_end)) begin
            hold_n = bus.data_i;
            full_n = 1'b1;
        end

        // Line level follows the next state so it changes on the same edge.
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shifter <= '0;
            hold    <= '0;
            full    <= 1'b0;
            uart_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shifter <= shift_n;
            hold    <= hold_n;
            full    <= full_n;
            uart_tx <= tx_n;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end
endmodule
